game_clock_timer: RTL and testbench

//  Match countdown timer producing the m / s10 / s1 time digits that the register file

---
 rtl/game_clock_timer_pkg.sv | 45 ++++
 rtl/game_clock_timer_tick_divider.sv | 38 +++
 rtl/game_clock_timer.sv | 107 ++++++++++
 tb/tb_game_clock_timer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/game_clock_timer_pkg.sv
// Shared definitions for the match countdown timer: state encodings, digit
// width, the packed time record and the one-second BCD decrement helpers.
package game_clock_timer_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] m;
        logic [DIGIT_W-1:0] s10;
        logic [DIGIT_W-1:0] s1;
    } game_time_t;

    // True when the time reads 0:00.
    function automatic logic time_is_zero(input game_time_t t);
        return (t.m == 4'd0) && (t.s10 == 4'd0) && (t.s1 == 4'd0);
    endfunction

    // Subtract one second in BCD; 0:00 saturates so the clock never underflows.
    function automatic game_time_t bcd_dec(input game_time_t t);
        game_time_t r;
        r = t;
        if (time_is_zero(t)) begin
            r = t;
        end else if (t.s1 != 4'd0) begin
            r.s1 = t.s1 - 4'd1;
        end else begin
            r.s1 = 4'd9;
            if (t.s10 != 4'd0) begin
                r.s10 = t.s10 - 4'd1;
            end else begin
                r.s10 = 4'd5;
                r.m   = t.m - 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_clock_timer_tick_divider.sv
// Prescaler for the game clock: counts system clocks while enabled and emits
// a one-cycle tick on the last cycle of each displayed second.
module tick_divider #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clock,
    input  logic ctrl_reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = enable && (cnt_q == LAST);

    // Advance the partial-second count while enabled; hold it otherwise so a
    // pause keeps the fraction of the current second.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            if (tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_q <= cnt_q;
        end
    end

endmodule

// File: rtl/game_clock_timer.sv
// Match countdown timer. Counts M:SS down at one second per CLK_HZ clocks,
// controlled by start/pause pulses, and pulses expired on reaching 0:00.
module game_clock_timer
    import game_clock_timer_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int START_MIN = 3,
    parameter int START_S10 = 0,
    parameter int START_S1  = 0
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        start,
    input  logic        pause,
    output logic [31:0] m,
    output logic [31:0] s10,
    output logic [31:0] s1,
    output logic        running,
    output logic        expired
);

    localparam game_time_t PRESET = '{
        m:   DIGIT_W'(START_MIN),
        s10: DIGIT_W'(START_S10),
        s1:  DIGIT_W'(START_S1)
    };

    state_e     state_q;
    game_time_t time_q;
    game_time_t time_dec_d;
    logic       expired_q;
    logic       start_only_s;
    logic       pause_only_s;
    logic       reload_s;
    logic       tick_s;

    // Simultaneous start and pause cancel each other out.
    assign start_only_s = start && !pause;
    assign pause_only_s = pause && !start;
    assign reload_s     = start_only_s && ((state_q == ST_IDLE) || (state_q == ST_EXPIRED));

    tick_divider #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_divider (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .enable     (state_q == ST_RUN),
        .clear      (reload_s),
        .tick       (tick_s)
    );

    // Next time value should the current cycle carry a tick.
    always_comb begin
        time_dec_d = bcd_dec(time_q);
    end

    // Control FSM: state, displayed time and the one-cycle expiry pulse.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q   <= ST_IDLE;
            time_q    <= PRESET;
            expired_q <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_EXPIRED: begin
                    if (start_only_s) begin
                        time_q <= PRESET;
                        if (time_is_zero(PRESET)) begin
                            state_q   <= ST_EXPIRED;
                            expired_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        time_q <= time_dec_d;
                    end
                    // Expiry wins over a pause landing on the final tick.
                    if (tick_s && time_is_zero(time_dec_d)) begin
                        state_q   <= ST_EXPIRED;
                        expired_q <= 1'b1;
                    end else if (pause_only_s) begin
                        state_q <= ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (start_only_s) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m       = {28'd0, time_q.m};
    assign s10     = {28'd0, time_q.s10};
    assign s1      = {28'd0, time_q.s1};
    assign running = (state_q == ST_RUN);
    assign expired = expired_q;

endmodule

// File: tb/tb_game_clock_timer.sv
// Bench for game_clock_timer: three instances (presets 0:12, 1:00, 0:00)
// share one stimulus stream; a seconds-based model is checked every cycle
// and directed literal expectations pin the key moments.
module tb_game_clock_timer;

    localparam int HZ = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    logic st  = 1'b0;
    logic pa  = 1'b0;

    logic [31:0] om [3];
    logic [31:0] os10 [3];
    logic [31:0] os1 [3];
    logic        orun [3];
    logic        oexp [3];

    game_clock_timer #(.CLK_HZ(HZ), .START_MIN(0), .START_S10(1), .START_S1(2)) dut0 (
        .clock(clk), .ctrl_reset(rst), .start(st), .pause(pa),
        .m(om[0]), .s10(os10[0]), .s1(os1[0]), .running(orun[0]), .expired(oexp[0]));
    game_clock_timer #(.CLK_HZ(HZ), .START_MIN(1), .START_S10(0), .START_S1(0)) dut1 (
        .clock(clk), .ctrl_reset(rst), .start(st), .pause(pa),
        .m(om[1]), .s10(os10[1]), .s1(os1[1]), .running(orun[1]), .expired(oexp[1]));
    game_clock_timer #(.CLK_HZ(HZ), .START_MIN(0), .START_S10(0), .START_S1(0)) dut2 (
        .clock(clk), .ctrl_reset(rst), .start(st), .pause(pa),
        .m(om[2]), .s10(os10[2]), .s1(os1[2]), .running(orun[2]), .expired(oexp[2]));

    int tests = 0;
    int fails = 0;

    // Model: remaining time as plain seconds, plus cycles spent running in
    // the current second. States: 0 idle, 1 run, 2 paused, 3 expired.
    int pre_sec [3] = '{12, 60, 0};
    int mst [3];
    int rem [3];
    int ph [3];
    bit mexp [3];
    bit mvalid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            mexp[i] = 1'b0;
            if (rst) begin
                mst[i] = 0; rem[i] = pre_sec[i]; ph[i] = 0;
            end else if (mst[i] == 0 || mst[i] == 3) begin
                if (st && !pa) begin
                    rem[i] = pre_sec[i]; ph[i] = 0;
                    if (rem[i] == 0) begin mst[i] = 3; mexp[i] = 1'b1; end
                    else mst[i] = 1;
                end
            end else if (mst[i] == 1) begin
                ph[i] = ph[i] + 1;
                if (ph[i] == HZ) begin
                    ph[i] = 0;
                    rem[i] = rem[i] - 1;
                    if (rem[i] == 0) begin mst[i] = 3; mexp[i] = 1'b1; end
                    else if (pa && !st) mst[i] = 2;
                end else if (pa && !st) begin
                    mst[i] = 2;
                end
            end else begin
                if (st && !pa) mst[i] = 1;
            end
        end
    endtask

    // One clock with the given pulses; the model follows the same edge.
    task automatic cyc(input logic r, input logic s, input logic p);
        rst = r; st = s; pa = p;
        @(posedge clk);
        model_step();
        if (r) mvalid = 1'b1;
        #1;
        rst = 1'b0; st = 1'b0; pa = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_time(input string name, input int i, input int mm, input int tt, input int ss);
        check({name, "_m"},   om[i],   32'(mm));
        check({name, "_s10"}, os10[i], 32'(tt));
        check({name, "_s1"},  os1[i],  32'(ss));
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("cmp%0d_m", i),   om[i],   32'(rem[i] / 60));
                check($sformatf("cmp%0d_s10", i), os10[i], 32'((rem[i] % 60) / 10));
                check($sformatf("cmp%0d_s1", i),  os1[i],  32'(rem[i] % 10));
                check($sformatf("cmp%0d_run", i), 32'(orun[i]), 32'(mst[i] == 1));
                check($sformatf("cmp%0d_exp", i), 32'(oexp[i]), 32'(mexp[i]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset state
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check_time("rst", 0, 0, 1, 2);
        check("rst_run", 32'(orun[0]), 32'd0);
        check("rst_exp", 32'(oexp[0]), 32'd0);

        // Start: 0:12 runs; 0:00 preset expires on the same edge
        cyc(1'b0, 1'b1, 1'b0);
        check("start_run", 32'(orun[0]), 32'd1);
        check("zero_exp", 32'(oexp[2]), 32'd1);
        check("zero_run", 32'(orun[2]), 32'd0);
        idle(1);
        check("zero_exp_drop", 32'(oexp[2]), 32'd0);
        idle(2);
        check("pre_tick_s1", os1[0], 32'd2);
        idle(1);
        check("tick4_s1", os1[0], 32'd1);
        check_time("borrow2", 1, 0, 5, 9);
        check("model_rem4", 32'(rem[0]), 32'd11);
        idle(4);
        check_time("tick8", 0, 0, 1, 0);
        idle(4);
        check_time("tick12", 0, 0, 0, 9);
        check("model_rem12", 32'(rem[0]), 32'd9);

        // Pause keeps the partial second
        idle(1);
        cyc(1'b0, 1'b0, 1'b1);
        check("pause_run", 32'(orun[0]), 32'd0);
        idle(20);
        check_time("frozen", 0, 0, 0, 9);
        cyc(1'b0, 1'b1, 1'b0);
        check("resume_run", 32'(orun[0]), 32'd1);
        idle(1);
        check("resume1_s1", os1[0], 32'd9);
        idle(1);
        check("resume2_s1", os1[0], 32'd8);

        // start+pause together ignored; pause while paused ignored
        cyc(1'b0, 1'b1, 1'b1);
        check("both_run", 32'(orun[0]), 32'd1);
        cyc(1'b0, 1'b0, 1'b1);
        check("pause2_run", 32'(orun[0]), 32'd0);
        cyc(1'b0, 1'b0, 1'b1);
        check("pause_paused_run", 32'(orun[0]), 32'd0);
        check("pause_paused_s1", os1[0], 32'd8);
        cyc(1'b0, 1'b1, 1'b0);

        // Reset at 0:07
        n = 0;
        while (os1[0] != 32'd7 && n < 40) begin idle(1); n++; end
        check("reach_007", 32'(n < 40), 32'd1);
        cyc(1'b1, 1'b0, 1'b0);
        check_time("midrst", 0, 0, 1, 2);
        check("midrst_run", 32'(orun[0]), 32'd0);
        check("midrst_exp", 32'(oexp[0]), 32'd0);

        // Run to expiry
        cyc(1'b0, 1'b1, 1'b0);
        n = 0;
        while (!oexp[0] && n < 60) begin idle(1); n++; end
        check("expire_latency", 32'(n), 32'd48);
        check_time("expire", 0, 0, 0, 0);
        check("expire_run", 32'(orun[0]), 32'd0);
        idle(1);
        check("expire_pulse_len", 32'(oexp[0]), 32'd0);
        idle(40);
        check_time("hold000", 0, 0, 0, 0);
        check("hold_run", 32'(orun[0]), 32'd0);
        cyc(1'b0, 1'b1, 1'b0);
        check_time("reload", 0, 0, 1, 2);
        check("reload_run", 32'(orun[0]), 32'd1);
        check("rezero_exp", 32'(oexp[2]), 32'd1);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
